cacheline_adaptor: RTL and testbench
====================================

# cacheline_adaptor

Synthesizable bridge between the last-level cache and the physical memory port. Accepts one whole-cache-line read or write from the cache, drives the burst memory protocol with `BURST_LEN` beats of `CACHE_LINE_WIDTH/BURST_LEN` bits each, and returns a single-cycle completion to the cache. Sits directly upstream of physical memory in the memory hierarchy.

## Interface
Parameters:
- `BURST_LEN`, 4, beats per line transfer
- `CACHE_LINE_WIDTH`, 256, line width in bits; burst width `BW = CACHE_LINE_WIDTH/BURST_LEN` (64 by default)
- `ADDR_WIDTH`, 32, byte address width

Ports:
- `clk` input 1: the block's single clock; all state updates on its rising edge
- `rst` input 1: reset, synchronous, active-high
- `line_i` input `CACHE_LINE_WIDTH`: write line from the cache
- `line_o` output `CACHE_LINE_WIDTH`: read line to the cache
- `address_i` input `ADDR_WIDTH`: line address from the cache
- `read_i` input 1: cache line read request
- `write_i` input 1: cache line write request
- `resp_o` output 1: one-cycle completion pulse
- `burst_i` input `BW`: read beat from memory
- `burst_o` output `BW`: write beat to memory
- `address_o` output `ADDR_WIDTH`: memory address
- `read_o` output 1: memory read
- `write_o` output 1: memory write
- `resp_i` input 1: memory beat valid / beat accepted

## Operation
- FSM states: IDLE, READ, WRITE, DONE. Beat counter `idx` of `$clog2(BURST_LEN)` bits. Line buffer `buf` of `CACHE_LINE_WIDTH` bits. Registered address `addr_q`.
- **IDLE**
  - If `write_i`: capture `line_i` into `buf` and `address_i` into `addr_q`, set `idx = 0`, then go to WRITE.
  - Else if `read_i`: capture `address_i`, set `idx = 0`, then go to READ.
  - If `read_i` and `write_i` are both high, write wins.
  - `resp_i` is ignored in IDLE.
- **READ**
  - `read_o = 1` and `address_o = {addr_q[ADDR_WIDTH-1:$clog2(CACHE_LINE_WIDTH/8)], zeros}`.
  - On each edge with `resp_i = 1`: `buf[BW*idx +: BW] <= burst_i` and `idx++`.
  - On the edge capturing beat `BURST_LEN-1`, go to DONE.
- **WRITE**
  - `write_o = 1`, same `address_o` as READ.
  - `burst_o = buf[BW*idx +: BW]`, combinational from the registered `idx`, so beat 0 is presented before memory responds.
  - On each edge with `resp_i = 1`: `idx++`.
  - On the edge where `resp_i = 1` and `idx == BURST_LEN-1`, go to DONE.
- **DONE**
  - `resp_o = 1` for exactly one cycle, `read_o = write_o = 0`, then go to IDLE.
  - `line_o = buf` always. It is valid in the DONE cycle of a read and is held until the next read overwrites `buf`.
- Cache inputs are ignored outside IDLE.
- `address_o`, `read_o` and `write_o` are constant for the whole transaction; memory flags any change as an error.

## Timing
- All outputs are registered or decoded from state/registered values only. No combinational path from a cache input to any memory output.
- The request is accepted on edge E0. `read_o`/`write_o` are high from E0 until the edge that captures the last beat.
- Memory asserts `resp_i` after D cycles (page miss/hit latency), then holds it for BURST_LEN consecutive cycles.
- Write data: beat i must be on `burst_o` during the cycle where `resp_i` is high for the i-th time. Memory samples it at the following edge, the same edge on which `idx` advances.
- `resp_o` is high in the cycle after the final beat edge. Next request is accepted no earlier than the cycle after `resp_o`.
- At least one idle cycle (`read_o = write_o = 0`) follows every transaction, so memory never sees a back-to-back request as a continuation.
- **Reset values:** `rst` high at any edge, including mid-burst, forces IDLE with `idx = 0`, `buf = 0` and `addr_q = 0`. This makes `read_o`, `write_o`, `resp_o` and `address_o` 0 and `line_o = 0` from the next cycle; `burst_o` then decodes to `buf[0 +: BW] = 0`. Any partial transfer is abandoned and no `resp_o` is issued.
- Gaps in `resp_i` mid-burst are tolerated: `idx` holds and the state holds.

## Structure
- Shared package `cache_mem_types` holds:
  - the `adaptor_state_t` enum (IDLE, READ, WRITE, DONE);
  - the default constants `LINE_WIDTH = 256`, `BURST_LEN = 4`, `ADDR_WIDTH = 32`;
  - the derived `BURST_WIDTH` and `OFFSET_BITS`.
- Single module, no sub-modules. The beat mux and demux are plain indexed part-selects.

## Test plan
- **Read, miss latency:** `read_i = 1`, address 0x0000_1234, memory line 0x0123…ABCD over 4 beats after 10 cycles -> `address_o = 0x0000_1220` steady. `line_o` equals the line with beats in little-endian order. `resp_o` is high exactly one cycle, four cycles after the first `resp_i`.
- **Write:** `line_i` = {64'hD, 64'hC, 64'hB, 64'hA}, address 0x40 -> `burst_o` = A, B, C, D on the four `resp_i` cycles. Memory image at 0x40 matches `line_i`. `write_o` drops when `resp_o` rises.
- **Simultaneous `read_i` and `write_i`:** address 0x80 -> only `write_o` asserts, and `read_o` stays 0 throughout.
- **Reset mid-burst:** `rst` pulsed after 2 read beats -> next cycle `read_o = 0`, `resp_o = 0`, `line_o = 0`. A following read of a new line completes correctly.
- **Back-to-back:** write to 0x100 then read from 0x100, the read requested in the cycle after `resp_o` -> at least one idle cycle between them. The read returns the written line, with no memory protocol errors.
- **Stalled beats:** `resp_i` pattern 1, 0, 1, 1, 0, 1 -> exactly 4 beats are captured in order and `resp_o` fires once.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and default geometry for the cache <-> memory burst bridge.
package cache_mem_types;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_LEN   = 4;
  localparam int ADDR_WIDTH  = 32;
  localparam int BURST_WIDTH = LINE_WIDTH / BURST_LEN;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Purpose: converts one whole-line cache read/write into a BURST_LEN-beat memory burst.
// Latency: request accepted on the edge it is seen in IDLE; resp_o pulses the cycle after the last beat.
// Backpressure: beats advance only on resp_i; gaps hold state and beat index, cache inputs ignored when busy.
module cacheline_adaptor #(
  parameter int BURST_LEN        = cache_mem_types::BURST_LEN,
  parameter int CACHE_LINE_WIDTH = cache_mem_types::LINE_WIDTH,
  parameter int ADDR_WIDTH       = cache_mem_types::ADDR_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CACHE_LINE_WIDTH-1:0]           line_i,
  output logic [CACHE_LINE_WIDTH-1:0]           line_o,
  input  logic [ADDR_WIDTH-1:0]                 address_i,
  input  logic                                  read_i,
  input  logic                                  write_i,
  output logic                                  resp_o,
  input  logic [CACHE_LINE_WIDTH/BURST_LEN-1:0] burst_i,
  output logic [CACHE_LINE_WIDTH/BURST_LEN-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]                 address_o,
  output logic                                  read_o,
  output logic                                  write_o,
  input  logic                                  resp_i
);
  import cache_mem_types::adaptor_state_t;
  import cache_mem_types::IDLE;
  import cache_mem_types::READ;
  import cache_mem_types::WRITE;
  import cache_mem_types::DONE;

  localparam int BW    = CACHE_LINE_WIDTH / BURST_LEN;
  localparam int IDX_W = $clog2(BURST_LEN);
  localparam int OFF   = $clog2(CACHE_LINE_WIDTH / 8);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BURST_LEN - 1);

  adaptor_state_t                state;
  logic [IDX_W-1:0]              idx;
  logic [CACHE_LINE_WIDTH-1:0]   line_buf;
  // Only the line-aligned part of the address is kept; the offset is always driven as zero.
  logic [ADDR_WIDTH-OFF-1:0]     addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      line_buf <= '0;
      addr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i) begin
            line_buf <= line_i;
            addr_q   <= address_i[ADDR_WIDTH-1:OFF];
            idx      <= '0;
            state    <= WRITE;
          end else if (read_i) begin
            addr_q <= address_i[ADDR_WIDTH-1:OFF];
            idx    <= '0;
            state  <= READ;
          end
        end
        READ: begin
          if (resp_i) begin
            line_buf[BW*idx +: BW] <= burst_i;
            if (idx == LAST) begin
              idx   <= '0;
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            if (idx == LAST) begin
              idx   <= '0;
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Every memory-side output decodes from registered state only.
  assign read_o    = (state == READ);
  assign write_o   = (state == WRITE);
  assign resp_o    = (state == DONE);
  assign address_o = {addr_q, {OFF{1'b0}}};
  assign burst_o   = line_buf[BW*idx +: BW];
  assign line_o    = line_buf;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomised bench for cacheline_adaptor against a line-granular memory model.
module tb_cacheline_adaptor;
  localparam int BL = 4;
  localparam int LW = 256;
  localparam int BW = LW / BL;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [LW-1:0] line_i = '0;
  logic [LW-1:0] line_o;
  logic [AW-1:0] address_i = '0;
  logic          read_i = 1'b0;
  logic          write_i = 1'b0;
  logic          resp_o;
  logic [BW-1:0] burst_i = '0;
  logic [BW-1:0] burst_o;
  logic [AW-1:0] address_o;
  logic          read_o;
  logic          write_o;
  logic          resp_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory: whole lines keyed by line-aligned byte address.
  logic [LW-1:0] mem [logic [AW-1:0]];

  cacheline_adaptor #(.BURST_LEN(BL), .CACHE_LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o), .address_i(address_i),
    .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .burst_i(burst_i),
    .burst_o(burst_o), .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Runs one cache request starting at the current negedge.
  // gap_mode: 0 = back-to-back beats, 1 = random gaps, 2 = fixed 1,0,1,1,0,1 pattern.
  task automatic run_txn(input bit rd, input bit wr, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wline, input int delay, input int gap_mode);
    logic [AW-1:0] a_exp;
    logic [LW-1:0] rline;
    logic [LW-1:0] got;
    bit            is_wr;
    bit            stable;
    bit            go;
    bit            pat [6];
    int            beats;
    int            cyc;
    int            pidx;
    pat    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    a_exp  = {addr[AW-1:5], 5'b0};
    is_wr  = wr;
    got    = '0;
    stable = 1'b1;
    if (!is_wr && !mem.exists(a_exp)) mem[a_exp] = rand_line();
    rline  = is_wr ? '0 : mem[a_exp];

    read_i = rd; write_i = wr; address_i = addr; line_i = wline;
    @(negedge clk);
    read_i = 1'b0; write_i = 1'b0; address_i = $urandom; line_i = rand_line();

    chk("req_read_o", read_o, !is_wr);
    chk("req_write_o", write_o, is_wr);
    chk("req_address_o", address_o, a_exp);

    beats = 0; cyc = 0; pidx = 0;
    while (beats < BL && cyc < 500) begin
      if (read_o !== !is_wr || write_o !== is_wr || address_o !== a_exp || resp_o !== 1'b0)
        stable = 1'b0;
      if (cyc < delay) go = 1'b0;
      else begin
        case (gap_mode)
          1:       go = ($urandom_range(0, 2) != 0);
          2:       go = (pidx < 6) ? pat[pidx] : 1'b1;
          default: go = 1'b1;
        endcase
        pidx++;
      end
      if (go) begin
        resp_i = 1'b1;
        if (is_wr) got[beats*BW +: BW] = burst_o;
        else       burst_i = rline[beats*BW +: BW];
        beats++;
      end else begin
        resp_i  = 1'b0;
        burst_i = $urandom;
      end
      @(negedge clk);
      cyc++;
    end
    resp_i = 1'b0; burst_i = $urandom;

    chk("beat_count", beats, BL);
    chk("protocol_stable", stable, 1'b1);
    chk("done_resp_o", resp_o, 1'b1);
    chk("done_rw_low", {read_o, write_o}, 2'b00);
    if (is_wr) begin
      chk("write_beats", got, wline);
      mem[a_exp] = wline;
    end else begin
      chk("read_line_o", line_o, rline);
    end

    @(negedge clk);
    chk("resp_single", resp_o, 1'b0);
    chk("idle_gap", {read_o, write_o}, 2'b00);
  endtask

  initial begin
    logic [LW-1:0] l0;
    logic [LW-1:0] lw;
    bit            r;
    bit            w;
    repeat (3) @(negedge clk);
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_address_o", address_o, '0);
    chk("rst_line_o", line_o, '0);
    chk("rst_burst_o", burst_o, '0);
    rst = 1'b0;
    @(negedge clk);

    l0 = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_89ABCDEF0123ABCD;
    mem[32'h0000_1220] = l0;
    run_txn(1'b1, 1'b0, 32'h0000_1234, '0, 10, 0);

    run_txn(1'b0, 1'b1, 32'h0000_0040,
            {64'hD, 64'hC, 64'hB, 64'hA}, 3, 0);
    chk("mem_0x40", mem[32'h0000_0040], {64'hD, 64'hC, 64'hB, 64'hA});

    run_txn(1'b1, 1'b1, 32'h0000_0080, rand_line(), 2, 0);

    // Abandon a read after two beats.
    read_i = 1'b1; address_i = 32'h0000_0200;
    @(negedge clk);
    read_i = 1'b0;
    resp_i = 1'b1; burst_i = 64'h1111_2222_3333_4444;
    @(negedge clk);
    burst_i = 64'h5555_6666_7777_8888;
    @(negedge clk);
    resp_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_read_o", read_o, 1'b0);
    chk("midrst_resp_o", resp_o, 1'b0);
    chk("midrst_line_o", line_o, '0);
    chk("midrst_address_o", address_o, '0);
    @(negedge clk);
    chk("midrst_no_resp", resp_o, 1'b0);
    run_txn(1'b1, 1'b0, 32'h0000_0300, '0, 4, 0);

    lw = rand_line();
    run_txn(1'b0, 1'b1, 32'h0000_0100, lw, 1, 0);
    run_txn(1'b1, 1'b0, 32'h0000_0100, '0, 0, 0);
    chk("b2b_readback", line_o, lw);

    run_txn(1'b1, 1'b0, 32'h0000_0500, '0, 2, 2);
    run_txn(1'b0, 1'b1, 32'h0000_0520, rand_line(), 2, 2);

    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 1);
      w = $urandom_range(0, 1);
      if (!r && !w) r = 1'b1;
      run_txn(r, w, (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31)),
              rand_line(), $urandom_range(0, 8), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
